// File: rtl/pkt_hdr_extract_pkg.sv
// Shared types and constants for the packet header extractor: ethertypes,
// IP protocol numbers, ip_ver encoding and the metadata record.
package pkt_hdr_extract_pkg;

    localparam int WIN_BYTES = 64;
    localparam int WIN_W     = WIN_BYTES * 8;

    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [15:0] ETH_IPV6  = 16'h86DD;
    localparam logic [15:0] ETH_VLAN  = 16'h8100;
    localparam logic [7:0]  PROTO_TCP = 8'd6;
    localparam logic [7:0]  PROTO_UDP = 8'd17;

    typedef enum logic [1:0] {
        IPV_NONE = 2'd0,
        IPV_4    = 2'd1,
        IPV_6    = 2'd2
    } ip_ver_e;

    typedef struct packed {
        ip_ver_e      ip_ver;
        logic [7:0]   proto;
        logic [127:0] src_ip;
        logic [127:0] dst_ip;
        logic [15:0]  src_port;
        logic [15:0]  dst_port;
        logic         ports_vld;
        logic [11:0]  vlan_id;
        logic         vlan_vld;
        logic         trunc;
    } pkt_meta_t;

    // Byte 0 of the window sits in the most significant byte.
    function automatic logic [7:0] win_byte(input logic [WIN_W-1:0] w, input int idx);
        return w[WIN_W-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/pkt_hdr_parse.sv
// Combinational L2/L3/L4 header decode of a 64-byte window with a valid-byte count.
// Define PKT_HDR_VLAN_EN to parse a single 802.1Q tag.
module pkt_hdr_parse
    import pkt_hdr_extract_pkg::*;
(
    input  logic [WIN_W-1:0] win,
    input  logic [6:0]       nbytes,
    output pkt_meta_t        meta
);

    int          l2;
    int          poff;
    int          nb;
    logic [15:0] etype;
    logic [7:0]  vb;
    logic [7:0]  proto;
    logic        trunc;
    pkt_meta_t   m;

    always_comb begin
        m     = '0;
        trunc = 1'b0;
        nb    = int'(nbytes);
        l2    = 14;
        poff  = WIN_BYTES;
        vb    = '0;
        proto = '0;
        etype = {win_byte(win, 12), win_byte(win, 13)};
`ifdef PKT_HDR_VLAN_EN
        if (etype == ETH_VLAN && nb >= 14) begin
            if (nb < 18) begin
                trunc = 1'b1;
            end else begin
                m.vlan_id  = 12'({win_byte(win, 14), win_byte(win, 15)});
                m.vlan_vld = 1'b1;
                etype      = {win_byte(win, 16), win_byte(win, 17)};
                l2         = 18;
            end
        end
`endif
        if (nb < 14) begin
            trunc = 1'b1;
        end else if (!trunc && (etype == ETH_IPV4 || etype == ETH_IPV6)) begin
            if (nb <= l2) begin
                trunc = 1'b1;
            end else begin
                vb = win_byte(win, l2);
                if (etype == ETH_IPV4 && vb[7:4] == 4'd4 && vb[3:0] >= 4'd5) begin
                    if (nb < l2 + 20) begin
                        trunc = 1'b1;
                    end else begin
                        m.ip_ver = IPV_4;
                        proto    = win_byte(win, l2 + 9);
                        for (int k = 0; k < 4; k++) begin
                            m.src_ip[31-8*k -: 8] = win_byte(win, l2 + 12 + k);
                            m.dst_ip[31-8*k -: 8] = win_byte(win, l2 + 16 + k);
                        end
                        poff = l2 + 4 * int'(vb[3:0]);
                    end
                end else if (etype == ETH_IPV6 && vb[7:4] == 4'd6) begin
                    if (nb < l2 + 40) begin
                        trunc = 1'b1;
                    end else begin
                        m.ip_ver = IPV_6;
                        proto    = win_byte(win, l2 + 6);
                        for (int k = 0; k < 16; k++) begin
                            m.src_ip[127-8*k -: 8] = win_byte(win, l2 + 8 + k);
                            m.dst_ip[127-8*k -: 8] = win_byte(win, l2 + 24 + k);
                        end
                        poff = l2 + 40;
                    end
                end
            end
        end
        m.proto = proto;
        // nb never exceeds the window, so this also bounds the ports to it.
        if (m.ip_ver != IPV_NONE && (proto == PROTO_TCP || proto == PROTO_UDP) &&
            poff + 4 <= nb) begin
            m.src_port  = {win_byte(win, poff),     win_byte(win, poff + 1)};
            m.dst_port  = {win_byte(win, poff + 2), win_byte(win, poff + 3)};
            m.ports_vld = 1'b1;
        end
        if (trunc) begin
            m       = '0;
            m.trunc = 1'b1;
        end
        meta = m;
    end

endmodule

// File: rtl/pkt_hdr_extract.sv
// AXI-stream pass-through that captures the first 64 header bytes of each packet
// and emits one parsed metadata record per packet.
module pkt_hdr_extract
    import pkt_hdr_extract_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int HDR_BYTES = 64
) (
    input  logic                axis_aclk,
    input  logic                axis_rst,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic                meta_valid,
    input  logic                meta_ready,
    output logic [1:0]          meta_ip_ver,
    output logic [7:0]          meta_proto,
    output logic [127:0]        meta_src_ip,
    output logic [127:0]        meta_dst_ip,
    output logic [15:0]         meta_src_port,
    output logic [15:0]         meta_dst_port,
    output logic                meta_ports_vld,
    output logic [11:0]         meta_vlan_id,
    output logic                meta_vlan_vld,
    output logic                meta_trunc
);

    localparam int KEEP_W    = DATA_W / 8;
    localparam int HDR_BEATS = HDR_BYTES * 8 / DATA_W;

    typedef enum logic [1:0] {ST_FIRST, ST_HDR, ST_BODY} state_e;

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d, win_cur;
    logic             meta_valid_q, meta_valid_d;
    pkt_meta_t        meta_q, meta_d, parsed;
    logic [6:0]       nbytes;
    logic             in_hdr, comp, stall, xfer;
    int               kcnt;

    assign in_hdr = (state_q != ST_BODY);
    assign comp   = in_hdr && (cnt_q == 16'(HDR_BEATS - 1) || s_axis_tlast);
    assign stall  = meta_valid_q && !meta_ready && comp;
    assign xfer   = s_axis_tvalid && s_axis_tready;

    assign s_axis_tready = m_axis_tready && !stall;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    // Hidden while stalled so downstream cannot take a beat upstream will repeat.
    assign m_axis_tvalid = s_axis_tvalid && !stall;

    always_comb begin
        kcnt = 0;
        for (int j = 0; j < KEEP_W; j++) begin
            if (s_axis_tkeep[KEEP_W-1-j]) kcnt = j + 1;
        end
        nbytes  = 7'(int'(cnt_q) * KEEP_W + (s_axis_tlast ? kcnt : KEEP_W));
        win_cur = (state_q == ST_FIRST) ? '0 : win_q;
        if (in_hdr && cnt_q < 16'(HDR_BEATS)) begin
            win_cur[WIN_W-1-int'(cnt_q)*DATA_W -: DATA_W] = s_axis_tdata;
        end
    end

    pkt_hdr_parse u_parse (
        .win    (win_cur),
        .nbytes (nbytes),
        .meta   (parsed)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        meta_valid_d = meta_valid_q && !meta_ready;
        meta_d       = meta_q;
        if (xfer) begin
            if (in_hdr) win_d = win_cur;
            if (s_axis_tlast) begin
                state_d = ST_FIRST;
                cnt_d   = '0;
            end else begin
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
                state_d = (!in_hdr || comp) ? ST_BODY : ST_HDR;
            end
            if (comp) begin
                meta_valid_d = 1'b1;
                meta_d       = parsed;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q      <= ST_FIRST;
            cnt_q        <= '0;
            win_q        <= '0;
            meta_valid_q <= 1'b0;
            meta_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            meta_valid_q <= meta_valid_d;
            meta_q       <= meta_d;
        end
    end

    assign meta_valid     = meta_valid_q;
    assign meta_ip_ver    = meta_q.ip_ver;
    assign meta_proto     = meta_q.proto;
    assign meta_src_ip    = meta_q.src_ip;
    assign meta_dst_ip    = meta_q.dst_ip;
    assign meta_src_port  = meta_q.src_port;
    assign meta_dst_port  = meta_q.dst_port;
    assign meta_ports_vld = meta_q.ports_vld;
    assign meta_vlan_id   = meta_q.vlan_id;
    assign meta_vlan_vld  = meta_q.vlan_vld;
    assign meta_trunc     = meta_q.trunc;

endmodule

// File: tb/tb_pkt_hdr_extract.sv
// Directed bench for pkt_hdr_extract: a 512-bit instance for single-beat frames
// and stall, a 128-bit instance for multi-beat headers and reset mid-packet.
module tb_pkt_hdr_extract;

    typedef struct packed {
        logic [1:0]   ver;
        logic [7:0]   proto;
        logic [127:0] src;
        logic [127:0] dst;
        logic [15:0]  sp;
        logic [15:0]  dp;
        logic         pv;
        logic [11:0]  vid;
        logic         vv;
        logic         tr;
    } meta_s;

    typedef struct {
        int         kind;   // 0 IPv4, 1 IPv6, 2 other ethertype
        int         ihl;
        logic [7:0] proto;
        int         len;
        bit         vlan;
        meta_s      exp;
    } vec_t;

    localparam logic [127:0] V4S = {96'd0, 32'h0A000001};
    localparam logic [127:0] V4D = {96'd0, 32'h0A000002};
    localparam logic [127:0] V6S = 128'h20010db8_00000000_00000000_00000001;
    localparam logic [127:0] V6D = 128'h20010db8_00000000_00000000_00000002;
    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [511:0] a_tdata, a_m_tdata;
    logic [63:0]  a_tkeep, a_m_tkeep;
    logic a_tvalid, a_tlast, a_tready, a_m_tvalid, a_m_tlast, a_m_tready, a_mv, a_mr;
    logic [1:0] a_ver; logic [7:0] a_proto; logic [127:0] a_src, a_dst;
    logic [15:0] a_sp, a_dp; logic a_pv, a_vv, a_tr; logic [11:0] a_vid;
    meta_s a_obs;
    assign a_obs = {a_ver, a_proto, a_src, a_dst, a_sp, a_dp, a_pv, a_vid, a_vv, a_tr};

    logic [127:0] b_tdata, b_m_tdata;
    logic [15:0]  b_tkeep, b_m_tkeep;
    logic b_tvalid, b_tlast, b_tready, b_m_tvalid, b_m_tlast, b_m_tready, b_mv, b_mr;
    logic [1:0] b_ver; logic [7:0] b_proto; logic [127:0] b_src, b_dst;
    logic [15:0] b_sp, b_dp; logic b_pv, b_vv, b_tr; logic [11:0] b_vid;
    meta_s b_obs;
    assign b_obs = {b_ver, b_proto, b_src, b_dst, b_sp, b_dp, b_pv, b_vid, b_vv, b_tr};

    pkt_hdr_extract #(.DATA_W(512)) dut_a (
        .axis_aclk(clk), .axis_rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
        .s_axis_tlast(a_tlast), .s_axis_tready(a_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
        .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready),
        .meta_valid(a_mv), .meta_ready(a_mr), .meta_ip_ver(a_ver), .meta_proto(a_proto),
        .meta_src_ip(a_src), .meta_dst_ip(a_dst), .meta_src_port(a_sp),
        .meta_dst_port(a_dp), .meta_ports_vld(a_pv), .meta_vlan_id(a_vid),
        .meta_vlan_vld(a_vv), .meta_trunc(a_tr)
    );

    pkt_hdr_extract #(.DATA_W(128)) dut_b (
        .axis_aclk(clk), .axis_rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
        .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready),
        .meta_valid(b_mv), .meta_ready(b_mr), .meta_ip_ver(b_ver), .meta_proto(b_proto),
        .meta_src_ip(b_src), .meta_dst_ip(b_dst), .meta_src_port(b_sp),
        .meta_dst_port(b_dp), .meta_ports_vld(b_pv), .meta_vlan_id(b_vid),
        .meta_vlan_vld(b_vv), .meta_trunc(b_tr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] pkt [0:127];
    vec_t vecs [NV];

    function automatic meta_s mk(input logic [1:0] v, input logic [7:0] p,
                                 input logic [127:0] s, input logic [127:0] d,
                                 input logic [15:0] sp, input logic [15:0] dp,
                                 input logic pv, input logic [11:0] vid,
                                 input logic vv, input logic tr);
        return '{v, p, s, d, sp, dp, pv, vid, vv, tr};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_meta(input string t, input meta_s act, input meta_s exp);
        chk({t, ".ver"},   128'(act.ver),   128'(exp.ver));
        chk({t, ".proto"}, 128'(act.proto), 128'(exp.proto));
        chk({t, ".src"},   act.src,         exp.src);
        chk({t, ".dst"},   act.dst,         exp.dst);
        chk({t, ".ports"}, 128'({act.sp, act.dp, act.pv}), 128'({exp.sp, exp.dp, exp.pv}));
        chk({t, ".vlan"},  128'({act.vid, act.vv}), 128'({exp.vid, exp.vv}));
        chk({t, ".trunc"}, 128'(act.tr),    128'(exp.tr));
    endtask

    task automatic build(input int kind, input int ihl, input logic [7:0] proto, input bit vlan);
        int l2 = 14;
        int po;
        for (int i = 0; i < 128; i++) pkt[i] = 8'hA5 ^ 8'(i);
        if (vlan) begin
            {pkt[12], pkt[13]} = 16'h8100;
            {pkt[14], pkt[15]} = 16'h0123;
            l2 = 18;
        end
        if (kind == 0) begin
            {pkt[l2-2], pkt[l2-1]} = 16'h0800;
            pkt[l2]   = {4'h4, 4'(ihl)};
            pkt[l2+9] = proto;
            for (int k = 0; k < 4; k++) begin
                pkt[l2+12+k] = V4S[31-8*k -: 8];
                pkt[l2+16+k] = V4D[31-8*k -: 8];
            end
            po = l2 + 4 * ihl;
            if (ihl >= 5 && po + 3 < 128) begin
                {pkt[po], pkt[po+1]}   = 16'd1234;
                {pkt[po+2], pkt[po+3]} = 16'd80;
            end
        end else if (kind == 1) begin
            {pkt[l2-2], pkt[l2-1]} = 16'h86DD;
            pkt[l2]   = 8'h60;
            pkt[l2+6] = proto;
            for (int k = 0; k < 16; k++) begin
                pkt[l2+8+k]  = V6S[127-8*k -: 8];
                pkt[l2+24+k] = V6D[127-8*k -: 8];
            end
            {pkt[l2+40], pkt[l2+41]} = 16'd443;
            {pkt[l2+42], pkt[l2+43]} = 16'd5000;
        end else begin
            {pkt[l2-2], pkt[l2-1]} = 16'h88CC;
        end
    endtask

    task automatic send_a(input int len);
        logic [511:0] d;
        logic [63:0]  k;
        int n = 0;
        for (int j = 0; j < 64; j++) begin
            d[511-8*j -: 8] = pkt[j];
            k[63-j] = (j < len);
        end
        a_tdata = d; a_tkeep = k; a_tlast = 1'b1; a_tvalid = 1'b1;
        #1;
        while (!a_tready && n < 40) begin @(negedge clk); #1; n++; end
        if (n == 40) begin n_cmp++; n_bad++; $display("FAIL a_tready_timeout: got 0 expected 1"); end
        chk("a.m_tvalid", 128'(a_m_tvalid), 128'(1));
        @(posedge clk); #1;
        a_tvalid = 1'b0; a_tlast = 1'b0;
    endtask

    task automatic beat_b(input int bi, input int len);
        logic [127:0] d;
        logic [15:0]  k;
        int n = 0;
        for (int j = 0; j < 16; j++) begin
            d[127-8*j -: 8] = pkt[16*bi+j];
            k[15-j] = (16*bi + j < len);
        end
        b_tdata = d; b_tkeep = k; b_tlast = (16*(bi+1) >= len); b_tvalid = 1'b1;
        #1;
        while (!b_tready && n < 40) begin @(negedge clk); #1; n++; end
        if (n == 40) begin n_cmp++; n_bad++; $display("FAIL b_tready_timeout: got 0 expected 1"); end
        chk("b.pass", b_m_tdata, d);
        chk("b.pass_ctl", 128'({b_m_tkeep, b_m_tlast, b_m_tvalid}), 128'({k, b_tlast, 1'b1}));
        @(posedge clk); #1;
        b_tvalid = 1'b0; b_tlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        meta_s zero, ma, mb;
        zero = '0;
        vecs[0]  = '{0, 5,  8'h11, 64, 0, mk(1, 8'h11, V4S, V4D, 1234, 80, 1, 0, 0, 0)};
        vecs[1]  = '{0, 5,  8'h06, 64, 0, mk(1, 8'h06, V4S, V4D, 1234, 80, 1, 0, 0, 0)};
        vecs[2]  = '{0, 5,  8'h01, 64, 0, mk(1, 8'h01, V4S, V4D, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{0, 15, 8'h11, 64, 0, mk(1, 8'h11, V4S, V4D, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{0, 4,  8'h11, 64, 0, zero};
        vecs[5]  = '{0, 5,  8'h11, 30, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[6]  = '{0, 5,  8'h11, 36, 0, mk(1, 8'h11, V4S, V4D, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{0, 5,  8'h11, 38, 0, mk(1, 8'h11, V4S, V4D, 1234, 80, 1, 0, 0, 0)};
        vecs[8]  = '{1, 0,  8'h06, 64, 0, mk(2, 8'h06, V6S, V6D, 443, 5000, 1, 0, 0, 0)};
        vecs[9]  = '{1, 0,  8'h06, 50, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[10] = '{2, 0,  8'h11, 64, 0, zero};
`ifdef PKT_HDR_VLAN_EN
        vecs[11] = '{0, 5,  8'h11, 64, 1, mk(1, 8'h11, V4S, V4D, 1234, 80, 1, 12'h123, 1, 0)};
`else
        vecs[11] = '{0, 5,  8'h11, 64, 1, zero};
`endif
        vecs[12] = '{0, 5,  8'h11, 13, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[13] = '{1, 0,  8'h06, 54, 0, mk(2, 8'h06, V6S, V6D, 0, 0, 0, 0, 0, 0)};

        rst = 1'b1;
        a_tdata = '0; a_tkeep = '0; a_tvalid = 0; a_tlast = 0; a_m_tready = 1; a_mr = 1;
        b_tdata = '0; b_tkeep = '0; b_tvalid = 0; b_tlast = 0; b_m_tready = 1; b_mr = 1;
        #12;
        chk("rst.a_mv", 128'(a_mv), 128'(0));
        chk_meta("rst.a", a_obs, zero);
        chk("rst.b_mv", 128'(b_mv), 128'(0));
        chk("rst.a_tready", 128'(a_tready), 128'(1));
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;

        // Single-beat frames on the 512-bit instance, meta_ready held high.
        for (int i = 0; i < NV; i++) begin
            build(vecs[i].kind, vecs[i].ihl, vecs[i].proto, vecs[i].vlan);
            send_a(vecs[i].len);
            chk($sformatf("v%0d.mv", i), 128'(a_mv), 128'(1));
            chk_meta($sformatf("v%0d", i), a_obs, vecs[i].exp);
            @(posedge clk); #1;
            chk($sformatf("v%0d.mv_drop", i), 128'(a_mv), 128'(0));
        end

        // Backpressure: second completing beat waits for the first record.
        ma = vecs[0].exp;
        mb = vecs[8].exp;
        a_mr = 1'b0;
        build(0, 5, 8'h11, 0);
        send_a(64);
        chk("stall.mv1", 128'(a_mv), 128'(1));
        build(1, 0, 8'h06, 0);
        @(negedge clk);
        for (int j = 0; j < 64; j++) begin
            a_tdata[511-8*j -: 8] = pkt[j];
            a_tkeep[63-j] = 1'b1;
        end
        a_tlast = 1'b1; a_tvalid = 1'b1;
        #1;
        chk("stall.tready", 128'(a_tready), 128'(0));
        chk("stall.pass", a_m_tdata[511:384], a_tdata[511:384]);
        chk("stall.pass_ctl", 128'({a_m_tkeep, a_m_tlast}), 128'({64'hFFFF_FFFF_FFFF_FFFF, 1'b1}));
        repeat (3) @(posedge clk);
        #1;
        chk("stall.tready_hold", 128'(a_tready), 128'(0));
        chk("stall.mv_hold", 128'(a_mv), 128'(1));
        chk_meta("stall.held", a_obs, ma);
        @(negedge clk); a_mr = 1'b1; #1;
        chk("stall.release", 128'(a_tready), 128'(1));
        @(posedge clk); #1;
        a_tvalid = 1'b0; a_tlast = 1'b0;
        chk("stall.mv2", 128'(a_mv), 128'(1));
        chk_meta("stall.second", a_obs, mb);
        @(posedge clk); #1;
        chk("stall.mv_drop", 128'(a_mv), 128'(0));

        // 128-bit instance: IPv6 TCP over five beats, header completes on beat 3.
        build(1, 0, 8'h06, 0);
        for (int bi = 0; bi < 5; bi++) begin
            beat_b(bi, 80);
            if (bi == 3) begin
                chk("b6.mv", 128'(b_mv), 128'(1));
                chk_meta("b6", b_obs, mb);
            end else begin
                chk($sformatf("b6.mv_beat%0d", bi), 128'(b_mv), 128'(0));
            end
        end

        // 30-byte IPv4 frame ending in beat 1 with partial tkeep.
        build(0, 5, 8'h11, 0);
        beat_b(0, 30);
        chk("b30.mv_beat0", 128'(b_mv), 128'(0));
        beat_b(1, 30);
        chk("b30.mv", 128'(b_mv), 128'(1));
        chk_meta("b30", b_obs, vecs[5].exp);
        @(posedge clk); #1;

        // Reset in the middle of a packet while a record is pending.
        b_mr = 1'b0;
        beat_b(0, 30);
        beat_b(1, 30);
        chk("brst.pending", 128'(b_mv), 128'(1));
        build(0, 5, 8'h11, 0);
        beat_b(0, 64);
        beat_b(1, 64);
        @(negedge clk); rst = 1'b1; #1;
        chk("brst.mv", 128'(b_mv), 128'(0));
        chk("brst.trunc", 128'(b_tr), 128'(0));
        @(negedge clk); rst = 1'b0; b_mr = 1'b1;
        for (int bi = 0; bi < 4; bi++) begin
            beat_b(bi, 64);
            if (bi < 3) chk($sformatf("brst.mv_beat%0d", bi), 128'(b_mv), 128'(0));
        end
        chk("brst.mv_new", 128'(b_mv), 128'(1));
        chk_meta("brst.new", b_obs, ma);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
